// File: rtl/facache_pkg.sv
// Shared constants, types and helpers for the fully-associative LRU cache.
// Pure declarations: no logic, no latency, no flow control.
package facache_pkg;

    localparam int FACACHE_N  = 8;
    localparam int FACACHE_AW = 16;
    localparam int FACACHE_DW = 16;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    typedef struct packed {
        logic                  v;
        logic [FACACHE_AW-1:0] tag;
        logic [FACACHE_DW-1:0] data;
    } entry_t;

endpackage

// File: rtl/facache_n_if.sv
// Request/response bundle of the cache: read, insert, invalidate, eviction, occupancy.
// Requests and responses are single-cycle pulses; there is no backpressure in either direction.
interface facache_n_if import facache_pkg::*; #(
    parameter int N  = FACACHE_N,
    parameter int AW = FACACHE_AW,
    parameter int DW = FACACHE_DW,
    parameter int IW = clog2(N)
);
    logic          rd_en;
    logic [AW-1:0] rd_adr;
    logic          rd_done;
    logic          rd_hit;
    logic [DW-1:0] rd_data;
    logic          ins_valid;
    logic [AW-1:0] ins_adr;
    logic [DW-1:0] ins_data;
    logic          inv_valid;
    logic [AW-1:0] inv_adr;
    logic          evict_valid;
    logic [AW-1:0] evict_adr;
    logic [DW-1:0] evict_data;
    logic [IW:0]   occupancy;

    modport master (
        output rd_en, rd_adr, ins_valid, ins_adr, ins_data, inv_valid, inv_adr,
        input  rd_done, rd_hit, rd_data, evict_valid, evict_adr, evict_data, occupancy
    );

    modport slave (
        input  rd_en, rd_adr, ins_valid, ins_adr, ins_data, inv_valid, inv_adr,
        output rd_done, rd_hit, rd_data, evict_valid, evict_adr, evict_data, occupancy
    );
endinterface

// File: rtl/facache_n_lru_ages.sv
// True-LRU age array (0 = MRU, N-1 = LRU) with two ordered touches per cycle.
// Touches take effect on the next edge; lru_idx reflects current state; never stalls.
module lru_ages import facache_pkg::*; #(
    parameter int N  = FACACHE_N,
    parameter int IW = clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          touch_a_en,
    input  logic [IW-1:0] touch_a_idx,
    input  logic          touch_b_en,
    input  logic [IW-1:0] touch_b_idx,
    output logic [IW-1:0] lru_idx
);
    logic [IW-1:0] age_q [N];
    logic [IW-1:0] age_m [N];
    logic [IW-1:0] age_d [N];
    logic [IW-1:0] ref_a;
    logic [IW-1:0] ref_b;

    // Touch b sees the ages already updated by touch a, so b always ends as MRU.
    always_comb begin
        ref_a = age_q[touch_a_idx];
        for (int i = 0; i < N; i++) begin
            age_m[i] = age_q[i];
            if (touch_a_en && age_q[i] < ref_a) age_m[i] = age_q[i] + IW'(1);
        end
        if (touch_a_en) age_m[touch_a_idx] = '0;

        ref_b = age_m[touch_b_idx];
        for (int i = 0; i < N; i++) begin
            age_d[i] = age_m[i];
            if (touch_b_en && age_m[i] < ref_b) age_d[i] = age_m[i] + IW'(1);
        end
        if (touch_b_en) age_d[touch_b_idx] = '0;
    end

    always_comb begin
        lru_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (age_q[i] == IW'(N - 1)) lru_idx = IW'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) age_q[i] <= IW'(i);
        end else begin
            for (int i = 0; i < N; i++) age_q[i] <= age_d[i];
        end
    end
endmodule

// File: rtl/facache_n.sv
// N-entry fully-associative cache with true-LRU replacement, write-update and invalidate.
// Read latency 1 cycle, eviction reported the cycle after the insert; no backpressure, never stalls.
module facache_n import facache_pkg::*; #(
    parameter int N  = FACACHE_N,
    parameter int AW = FACACHE_AW,
    parameter int DW = FACACHE_DW,
    parameter int IW = clog2(N)
) (
    input  logic       clk,
    input  logic       reset,
    facache_n_if.slave bus
);
    localparam int OW = IW + 1;

    typedef struct packed {
        logic          v;
        logic [AW-1:0] tag;
        logic [DW-1:0] data;
    } slot_t;

    slot_t ent_q [N];
    slot_t ent_d [N];

    logic          rd_hit_c, ins_hit, inv_hit, any_free, evict_c, inv_ok;
    logic [IW-1:0] rd_idx, ins_idx, inv_idx, free_idx, tgt_idx, lru_idx;

    logic          rd_done_q, rd_done_d;
    logic          rd_hit_q, rd_hit_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          evict_valid_q, evict_valid_d;
    logic [AW-1:0] evict_adr_q, evict_adr_d;
    logic [DW-1:0] evict_data_q, evict_data_d;
    logic [OW-1:0] occ_q, occ_d;

    // Descending scan leaves the lowest matching / lowest free index selected.
    always_comb begin
        rd_hit_c = 1'b0; rd_idx   = '0;
        ins_hit  = 1'b0; ins_idx  = '0;
        inv_hit  = 1'b0; inv_idx  = '0;
        any_free = 1'b0; free_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (ent_q[i].v && ent_q[i].tag == bus.rd_adr)  begin rd_hit_c = 1'b1; rd_idx  = IW'(i); end
            if (ent_q[i].v && ent_q[i].tag == bus.ins_adr) begin ins_hit  = 1'b1; ins_idx = IW'(i); end
            if (ent_q[i].v && ent_q[i].tag == bus.inv_adr) begin inv_hit  = 1'b1; inv_idx = IW'(i); end
            if (!ent_q[i].v) begin any_free = 1'b1; free_idx = IW'(i); end
        end
        tgt_idx = ins_hit ? ins_idx : (any_free ? free_idx : lru_idx);
        evict_c = bus.ins_valid && !ins_hit && !any_free;
        inv_ok  = bus.inv_valid && inv_hit && !(bus.ins_valid && bus.inv_adr == bus.ins_adr);
    end

    always_comb begin
        for (int i = 0; i < N; i++) ent_d[i] = ent_q[i];
        // Insert is applied after invalidate so it wins if both land on the LRU slot.
        if (inv_ok) ent_d[inv_idx].v = 1'b0;
        if (bus.ins_valid) ent_d[tgt_idx] = '{v: 1'b1, tag: bus.ins_adr, data: bus.ins_data};

        occ_d = '0;
        for (int i = 0; i < N; i++) occ_d = occ_d + OW'(ent_d[i].v);

        rd_done_d     = bus.rd_en;
        rd_hit_d      = bus.rd_en && rd_hit_c;
        rd_data_d     = (bus.rd_en && rd_hit_c) ? ent_q[rd_idx].data : '0;
        evict_valid_d = evict_c;
        evict_adr_d   = evict_c ? ent_q[lru_idx].tag  : evict_adr_q;
        evict_data_d  = evict_c ? ent_q[lru_idx].data : evict_data_q;
    end

    lru_ages #(.N(N), .IW(IW)) u_lru (
        .clk         (clk),
        .reset       (reset),
        .touch_a_en  (bus.rd_en && rd_hit_c),
        .touch_a_idx (rd_idx),
        .touch_b_en  (bus.ins_valid),
        .touch_b_idx (tgt_idx),
        .lru_idx     (lru_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) ent_q[i] <= '0;
            rd_done_q     <= 1'b0;
            rd_hit_q      <= 1'b0;
            rd_data_q     <= '0;
            evict_valid_q <= 1'b0;
            evict_adr_q   <= '0;
            evict_data_q  <= '0;
            occ_q         <= '0;
        end else begin
            for (int i = 0; i < N; i++) ent_q[i] <= ent_d[i];
            rd_done_q     <= rd_done_d;
            rd_hit_q      <= rd_hit_d;
            rd_data_q     <= rd_data_d;
            evict_valid_q <= evict_valid_d;
            evict_adr_q   <= evict_adr_d;
            evict_data_q  <= evict_data_d;
            occ_q         <= occ_d;
        end
    end

    assign bus.rd_done     = rd_done_q;
    assign bus.rd_hit      = rd_hit_q;
    assign bus.rd_data     = rd_data_q;
    assign bus.evict_valid = evict_valid_q;
    assign bus.evict_adr   = evict_adr_q;
    assign bus.evict_data  = evict_data_q;
    assign bus.occupancy   = occ_q;
endmodule

// File: doc/facache_n.md
Name: facache_n

Overview:
- Parametrised N-entry fully-associative cache with true-LRU replacement.
- Has one read port, one insert port, one invalidate port and a registered eviction output.
- Successor of the 4-word cache used for small victim/lookup buffers. Adds:
  - configurable depth and widths
  - synchronous reset
  - write-update on insert hit
  - explicit invalidation
  - concurrent read+insert
  - an occupancy count

Parameters:
- N, 8, number of entries; power of 2, 2..32
- AW, 16, address/tag width
- DW, 16, data width
- IW, $clog2(N), entry index / age width (derived; do not override)

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high; clears all valid bits and reinitialises ages
- rd_en  in  1  read request this cycle
- rd_adr  in  AW  read address
- rd_done  out  1  pulses 1 cycle after rd_en
- rd_hit  out  1  qualifies rd_data; meaningful only when rd_done=1
- rd_data  out  DW  hit data; 0 on miss
- ins_valid  in  1  insert request
- ins_adr  in  AW  insert address
- ins_data  in  DW  insert data
- inv_valid  in  1  invalidate request
- inv_adr  in  AW  address to invalidate
- evict_valid  out  1  one-cycle pulse: a valid entry was displaced
- evict_adr  out  AW  tag of the displaced entry
- evict_data  out  DW  data of the displaced entry
- occupancy  out  IW+1  count of valid entries

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Storage: per entry v, tag[AW], data[DW], age[IW]. Ages always form a permutation of 0..N-1; 0 = MRU, N-1 = LRU.
- Reset, on a posedge with reset=1:
  - v=0 for all entries; age[i]=i.
  - rd_done=0, rd_hit=0, rd_data=0, evict_valid=0, evict_adr=0, evict_data=0, occupancy=0.
  - All requests in that cycle are ignored.
- Hit test: v[i] && tag[i]==adr. At most one entry ever matches a given address.
- Read:
  - Latency 1. rd_done=1 in the cycle after rd_en, else 0.
  - On hit: rd_hit=1, rd_data=data[i], entry i touched.
  - On miss: rd_hit=0, rd_data=0, no LRU change.
  - Read sees pre-update contents (read-before-write) even if an insert or invalidate hits the same address in the same cycle.
- Insert:
  - If ins_adr hits entry i: data[i]<=ins_data, entry i touched, no eviction.
  - Else, if any entry is invalid: fill the lowest-index invalid entry and touch it.
  - Else: victim = the entry with age N-1. Next cycle evict_valid=1 and evict_adr/evict_data carry the victim's old contents; the victim is refilled and touched.
  - evict_valid is high for exactly one cycle. evict_adr/evict_data hold until the next eviction.
- Touch(i): every entry with age < age[i] increments; age[i]<=0.
  - Read touch and insert touch in the same cycle apply in order: read first, then insert. The insert entry ends as MRU and the read-hit entry (if different) at age 1.
- Invalidate:
  - If inv_adr hits entry i: v[i]<=0; ages unchanged.
  - If inv_adr==ins_adr in the same cycle, the insert wins and no invalidation occurs.
  - Invalidating a missing address is a no-op.
- Occupancy: registered; reflects state after the cycle's updates. Never exceeds N.
- Simultaneous rd_en, ins_valid and inv_valid are all legal and serviced in one cycle with the priority above. No stalls; the block has no backpressure.

Decomposition:
- Shared package facache_pkg:
  - default constants FACACHE_N, FACACHE_AW, FACACHE_DW
  - function clog2
  - typedef entry_t {v, tag, data}
- Sub-module lru_ages:
  - holds the age array; reset to identity
  - two touch inputs (touch_a_en/idx, touch_b_en/idx) applied in order
  - outputs lru_idx = index with age N-1
- Top: tag match, victim/first-invalid select, data storage, output registers.

Test Plan:
- Reset, then rd_en adr=0x0010 -> next cycle rd_done=1, rd_hit=0, rd_data=0; occupancy=0.
- N=4: insert 0xA0..0xA3 with data 0x1..0x4, then read 0xA2 -> rd_hit=1, rd_data=0x0003; occupancy=4; no evict_valid.
- Continuing: read 0xA0, then insert 0xB0/0x55 -> evict_valid=1 for 1 cycle, evict_adr=0xA1, evict_data=0x0002; read 0xA1 -> miss.
- Insert 0xA3 with data 0x99 when already present -> no eviction, occupancy unchanged; read 0xA3 -> 0x0099.
- Same cycle: rd_en 0xA3, ins 0xC0, inv 0xB0:
  - read returns the old 0xA3 data.
  - 0xC0 fills the slot freed by 0xB0 only on a later insert (freed after this cycle); this insert evicts the LRU.
  - Then invalidate 0xC0 while inserting 0xC0 -> entry stays valid.
- Assert reset mid-stream with a pending eviction -> next cycle all outputs 0, occupancy=0; a subsequent insert fills entry 0.
